nn_weight_fetch_ctrl: RTL and testbench



---
 rtl/nn_fetch_pkg.sv | 38 +++
 rtl/nn_weight_fetch_ctrl_if.sv | 34 +++
 rtl/flex_counter.sv | 36 +++
 rtl/nn_weight_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_nn_weight_fetch_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/nn_fetch_pkg.sv
// Shared types and constants for the neural-network weight fetch controller.
// Flash layout: hidden neurons packed first, output neurons from O_BASE upward.
package nn_fetch_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned WIDX_W    = 6;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned H_STRIDE  = 37;
    localparam int unsigned O_STRIDE  = 3;
    localparam int unsigned O_BASE    = 296;
    localparam int unsigned LAST_ADDR = 325;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        PRESENT,
        DONE
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              is_bias;
        logic [WIDX_W-1:0] word_idx;
    } fetch_word_t;

    // Word address of a neuron's bias; its weights follow contiguously.
    function automatic logic [ADDR_W-1:0] base_addr(input logic layer,
                                                    input logic [IDX_W-1:0] idx);
        if (layer) begin
            return ADDR_W'(O_BASE) + ADDR_W'(idx) * ADDR_W'(O_STRIDE);
        end
        return ADDR_W'(idx) * ADDR_W'(H_STRIDE);
    endfunction

endpackage

// File: rtl/nn_weight_fetch_ctrl_if.sv
// Request, word-stream and flash-pin bundle of the weight fetch controller.
interface nn_weight_fetch_ctrl_if;
    import nn_fetch_pkg::*;

    logic              start;
    logic              layer_sel;
    logic [IDX_W-1:0]  neuron_idx;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_is_bias;
    logic [WIDX_W-1:0] out_word_idx;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] fm_addr;
    logic              fm_ce;
    logic              fm_oe;
    logic              fm_we;
    logic [DATA_W-1:0] fm_data;

    modport master (
        input  start, layer_sel, neuron_idx, out_ready, fm_data,
        output out_valid, out_data, out_is_bias, out_word_idx,
               busy, done, err, fm_addr, fm_ce, fm_oe, fm_we
    );

    modport slave (
        output start, layer_sel, neuron_idx, out_ready, fm_data,
        input  out_valid, out_data, out_is_bias, out_word_idx,
               busy, done, err, fm_addr, fm_ce, fm_oe, fm_we
    );

endinterface

// File: rtl/flex_counter.sv
// Counts 1..rollover_val while enabled; rollover_flag is high in the cycle the
// count sits at rollover_val. Synchronous clear returns the count to 0.
module flex_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [CNT_W-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? CNT_W'(1) : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q       <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_q       <= count_d;
            rollover_flag <= (count_d == rollover_val);
        end
    end

endmodule

// File: rtl/nn_weight_fetch_ctrl.sv
// Fetches one neuron's bias and packed weight words from parallel flash and
// streams them to the compute datapath over valid/ready.
module nn_weight_fetch_ctrl
    import nn_fetch_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned H_NEURONS   = 8,
    parameter int unsigned H_WORDS     = 36,
    parameter int unsigned O_NEURONS   = 10,
    parameter int unsigned O_WORDS     = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    nn_weight_fetch_ctrl_if.master bus
);

    fetch_state_e      state;
    logic              layer_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] fm_addr_q;
    logic [WIDX_W-1:0] widx_q;
    fetch_word_t       word_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              ce_q;
    logic              oe_q;

    logic              req_in_range;
    logic [WIDX_W-1:0] last_idx;
    logic [WIDX_W-1:0] widx_inc;
    logic              cnt_en;
    logic              wait_done;

    assign req_in_range = bus.layer_sel ? (32'(bus.neuron_idx) < O_NEURONS)
                                        : (32'(bus.neuron_idx) < H_NEURONS);
    assign last_idx     = layer_q ? WIDX_W'(O_WORDS) : WIDX_W'(H_WORDS);
    assign widx_inc     = widx_q + WIDX_W'(1);
    assign cnt_en       = (state == SETUP) || (state == ACCESS);

    // Counting starts in SETUP so the flag lands on the last ACCESS cycle.
    flex_counter #(.CNT_W(CNT_W)) u_wait (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!cnt_en),
        .count_enable (cnt_en),
        .rollover_val (CNT_W'(WAIT_CYCLES)),
        .rollover_flag(wait_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            layer_q     <= 1'b0;
            base_q      <= '0;
            fm_addr_q   <= '0;
            widx_q      <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ce_q        <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (req_in_range) begin
                            layer_q   <= bus.layer_sel;
                            base_q    <= base_addr(bus.layer_sel, bus.neuron_idx);
                            fm_addr_q <= base_addr(bus.layer_sel, bus.neuron_idx);
                            widx_q    <= '0;
                            ce_q      <= 1'b1;
                            busy_q    <= 1'b1;
                            state     <= SETUP;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    oe_q  <= 1'b1;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (wait_done) begin
                        word_q.data     <= bus.fm_data;
                        word_q.is_bias  <= (widx_q == '0);
                        word_q.word_idx <= widx_q;
                        out_valid_q     <= 1'b1;
                        ce_q            <= 1'b0;
                        oe_q            <= 1'b0;
                        state           <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (widx_q == last_idx) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            widx_q    <= widx_inc;
                            fm_addr_q <= base_q + ADDR_W'(widx_inc);
                            ce_q      <= 1'b1;
                            state     <= SETUP;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = word_q.data;
    assign bus.out_is_bias  = word_q.is_bias;
    assign bus.out_word_idx = word_q.word_idx;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.fm_addr      = fm_addr_q;
    assign bus.fm_ce        = ce_q;
    assign bus.fm_oe        = oe_q;
    assign bus.fm_we        = 1'b0;

endmodule

// File: tb/tb_nn_weight_fetch_ctrl.sv
// Directed bench for nn_weight_fetch_ctrl: request table plus reset-abort and
// long-wait sequences against a flash model data[a] = a ^ 16'hA5A5.
module tb_nn_weight_fetch_ctrl;
    import nn_fetch_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    nn_weight_fetch_ctrl_if ifc  ();
    nn_weight_fetch_ctrl_if ifc5 ();

    assign ifc.fm_data  = ifc.fm_addr ^ 16'hA5A5;
    assign ifc5.fm_data = ifc5.fm_addr ^ 16'hA5A5;

    nn_weight_fetch_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (ifc)
    );

    nn_weight_fetch_ctrl #(.WAIT_CYCLES(5)) dut5 (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (ifc5)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       layer;
        logic [3:0] idx;
        bit         rand_ready;
        bit         extra_start;
        bit         exp_err;
        int         exp_words;
        int         exp_base;
        int         exp_done;
    } vec_t;

    vec_t vecs [7];

    // One request on the WAIT_CYCLES=2 instance; k counts edges after the start edge.
    task automatic run_req(input logic layer, input logic [3:0] idx, input bit rand_ready,
                           input bit extra_start, input bit exp_err, input int exp_words,
                           input int exp_base, input int exp_done);
        int          nwords  = 0;
        int          done_k  = -1;
        int          err_cnt = 0;
        bit          stalled = 1'b0;
        logic [15:0] held    = '0;
        logic [15:0] ea;
        @(negedge clk);
        ifc.start      = 1'b1;
        ifc.layer_sel  = layer;
        ifc.neuron_idx = idx;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (extra_start && k == 5) begin
                ifc.start      = 1'b1;
                ifc.layer_sel  = 1'b1;
                ifc.neuron_idx = 4'd10;
            end else begin
                ifc.start = 1'b0;
            end
            ifc.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ifc.err) err_cnt++;
            if (ifc.done) begin
                done_k = k;
                check("busy_at_done", 64'(ifc.busy), 64'd0);
                break;
            end
            if (exp_err) begin
                check("err_no_ce", 64'(ifc.fm_ce), 64'd0);
                check("err_no_busy", 64'(ifc.busy), 64'd0);
                if (k == 8) break;
            end else begin
                check("busy", 64'(ifc.busy), 64'd1);
            end
            ea = 16'(exp_base + nwords);
            if (ifc.fm_oe) check("fm_addr", 64'(ifc.fm_addr), 64'(ea));
            if (ifc.out_valid) begin
                if (stalled) check("stall_hold", 64'(ifc.out_data), 64'(held));
                if (ifc.out_ready) begin
                    check("data", 64'(ifc.out_data), 64'(ea ^ 16'hA5A5));
                    check("word_idx", 64'(ifc.out_word_idx), 64'(nwords));
                    check("is_bias", 64'(ifc.out_is_bias), 64'(nwords == 0));
                    nwords++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = ifc.out_data;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        ifc.start     = 1'b0;
        ifc.out_ready = 1'b1;
        check("err_pulses", 64'(err_cnt), exp_err ? 64'd1 : 64'd0);
        check("words", 64'(nwords), 64'(exp_words));
        if (exp_done >= 0) check("done_cycle", 64'(done_k), 64'(exp_done));
        if (!exp_err) check("done_seen", 64'(done_k >= 0), 64'd1);
    endtask

    initial begin
        int          oe_run  = 0;
        int          hs_prev = -1;
        int          done5   = -1;
        int          nw      = 0;
        logic [15:0] oe_addr = '0;

        n_rst           = 1'b0;
        ifc.start       = 1'b0;
        ifc.layer_sel   = 1'b0;
        ifc.neuron_idx  = '0;
        ifc.out_ready   = 1'b1;
        ifc5.start      = 1'b0;
        ifc5.layer_sel  = 1'b0;
        ifc5.neuron_idx = '0;
        ifc5.out_ready  = 1'b1;

        vecs[0] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 37, 0,   148};
        vecs[1] = '{1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 3,  323, 12};
        vecs[2] = '{1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 37, 259, -1};
        vecs[3] = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 0, 0,   -1};
        vecs[4] = '{1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 37, 185, 148};
        vecs[5] = '{1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 0,  0,   -1};
        vecs[6] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 3,  296, 12};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({ifc.out_valid, ifc.out_data, ifc.out_is_bias, ifc.out_word_idx, ifc.busy,
                   ifc.done, ifc.err, ifc.fm_addr, ifc.fm_ce, ifc.fm_oe, ifc.fm_we}), 64'd0);
        n_rst = 1'b1;

        foreach (vecs[i]) begin
            run_req(vecs[i].layer, vecs[i].idx, vecs[i].rand_ready, vecs[i].extra_start,
                    vecs[i].exp_err, vecs[i].exp_words, vecs[i].exp_base, vecs[i].exp_done);
        end

        // Abort hidden neuron 3 while the flash is being read, then refetch it.
        @(negedge clk);
        ifc.start      = 1'b1;
        ifc.layer_sel  = 1'b0;
        ifc.neuron_idx = 4'd3;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 10 && !ifc.fm_oe; i++) @(negedge clk);
        check("reach_access", 64'(ifc.fm_oe), 64'd1);
        n_rst = 1'b0;
        #1;
        check("abort_outputs",
              64'({ifc.out_valid, ifc.out_data, ifc.out_is_bias, ifc.out_word_idx, ifc.busy,
                   ifc.done, ifc.err, ifc.fm_addr, ifc.fm_ce, ifc.fm_oe, ifc.fm_we}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(ifc.done), 64'd0);
        end
        n_rst = 1'b1;
        run_req(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 37, 111, 148);

        // Long access wait on the second instance: output neuron 0.
        @(negedge clk);
        ifc5.start      = 1'b1;
        ifc5.layer_sel  = 1'b1;
        ifc5.neuron_idx = 4'd0;
        @(posedge clk);
        @(negedge clk);
        ifc5.start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (ifc5.done) begin
                done5 = k;
                break;
            end
            if (ifc5.fm_oe) begin
                if (oe_run == 0) begin
                    oe_addr = ifc5.fm_addr;
                    check("w5_addr", 64'(ifc5.fm_addr), 64'(296 + nw));
                end else begin
                    check("w5_addr_stable", 64'(ifc5.fm_addr), 64'(oe_addr));
                end
                oe_run++;
            end else if (oe_run != 0) begin
                check("w5_oe_len", 64'(oe_run), 64'd5);
                oe_run = 0;
            end
            if (ifc5.out_valid) begin
                check("w5_data", 64'(ifc5.out_data), 64'(16'(296 + nw) ^ 16'hA5A5));
                if (hs_prev >= 0) check("w5_period", 64'(k - hs_prev), 64'd7);
                hs_prev = k;
                nw++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("w5_words", 64'(nw), 64'd3);
        check("w5_done", 64'(done5), 64'd21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
